pacemaker_dual_param: RTL and testbench

// Parametrised dual-chamber pacemaker timing core; successor to the fixed-timing Pacemaker2.

---
 rtl/pacemaker_dual_param.sv | 156 +++++++++++++++
 tb/tb_pacemaker_dual_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pacemaker_dual_param.sv
// Dual-chamber pacemaker timing core with runtime mode select (DDD/VVI/AAI/OFF),
// refractory blanking, upper-rate limiting and one-cycle sense-event flags.
module pacemaker_dual_param #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LRI   = 100,
  parameter int unsigned AVI   = 30,
  parameter int unsigned URI   = 60,
  parameter int unsigned VRP   = 20,
  parameter int unsigned PVARP = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sa,
  input  logic       sv,
  input  logic [1:0] mode,
  output logic       pa,
  output logic       pv,
  output logic       as_evt,
  output logic       vs_evt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    VA_WAIT = 2'b00,
    AV_WAIT = 2'b01,
    IDLE    = 2'b10
  } state_t;

  localparam logic [1:0] MODE_DDD = 2'b00;
  localparam logic [1:0] MODE_VVI = 2'b01;
  localparam logic [1:0] MODE_AAI = 2'b10;
  localparam logic [1:0] MODE_OFF = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PA_AT     = CNT_W'(LRI - AVI - 1);
  localparam logic [CNT_W-1:0] LRI_LAST  = CNT_W'(LRI - 1);
  localparam logic [CNT_W-1:0] AV_LAST   = CNT_W'(AVI - 1);
  localparam logic [CNT_W-1:0] URI_LAST  = CNT_W'(URI - 1);
  localparam logic [CNT_W-1:0] VRP_C     = CNT_W'(VRP);
  localparam logic [CNT_W-1:0] PVARP_C   = CNT_W'(PVARP);

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] v_cnt, v_cnt_d, v_inc;
  logic [CNT_W-1:0] av_cnt, av_cnt_d, av_inc;
  logic             pa_d, pv_d, as_d, vs_d;
  logic             sa_ok, sv_ok;

  assign state = state_q;

  // Saturating increments and refractory-qualified senses
  always_comb begin
    v_inc  = (v_cnt == CNT_MAX) ? v_cnt : v_cnt + CNT_W'(1);
    av_inc = (av_cnt == AV_LAST) ? av_cnt : av_cnt + CNT_W'(1);
    sv_ok  = sv && (v_cnt >= VRP_C);
    sa_ok  = sa && (v_cnt >= PVARP_C);
  end

  // Next-state and next-output decode; a sense always wins over a pace timeout
  always_comb begin
    state_d  = state_q;
    v_cnt_d  = v_inc;
    av_cnt_d = '0;
    pa_d     = 1'b0;
    pv_d     = 1'b0;
    as_d     = 1'b0;
    vs_d     = 1'b0;

    if (mode != mode_q) begin
      state_d = (mode == MODE_OFF) ? IDLE : VA_WAIT;
      v_cnt_d = '0;
    end else begin
      case (mode_q)
        MODE_OFF: begin
          state_d = IDLE;
          v_cnt_d = '0;
        end

        MODE_VVI: begin
          state_d = VA_WAIT;
          if (sv_ok) begin
            vs_d    = 1'b1;
            v_cnt_d = '0;
          end else if (v_cnt == LRI_LAST) begin
            pv_d    = 1'b1;
            v_cnt_d = '0;
          end
        end

        MODE_AAI: begin
          state_d = VA_WAIT;
          if (sa_ok) begin
            as_d    = 1'b1;
            v_cnt_d = '0;
          end else if (v_cnt == LRI_LAST) begin
            pa_d    = 1'b1;
            v_cnt_d = '0;
          end
        end

        default: begin
          if (state_q == AV_WAIT) begin
            // pv waits for both AV delay expiry and the upper-rate limit
            if (sv_ok) begin
              vs_d    = 1'b1;
              v_cnt_d = '0;
              state_d = VA_WAIT;
            end else if ((av_cnt == AV_LAST) && (v_cnt >= URI_LAST)) begin
              pv_d    = 1'b1;
              v_cnt_d = '0;
              state_d = VA_WAIT;
            end else begin
              av_cnt_d = av_inc;
            end
          end else begin
            state_d = VA_WAIT;
            if (sv_ok) begin
              vs_d    = 1'b1;
              v_cnt_d = '0;
            end else if (sa_ok) begin
              as_d    = 1'b1;
              state_d = AV_WAIT;
            end else if (v_cnt == PA_AT) begin
              pa_d    = 1'b1;
              state_d = AV_WAIT;
            end
          end
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VA_WAIT;
      mode_q  <= mode;
      v_cnt   <= '0;
      av_cnt  <= '0;
      pa      <= 1'b0;
      pv      <= 1'b0;
      as_evt  <= 1'b0;
      vs_evt  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      v_cnt   <= v_cnt_d;
      av_cnt  <= av_cnt_d;
      pa      <= pa_d;
      pv      <= pv_d;
      as_evt  <= as_d;
      vs_evt  <= vs_d;
    end
  end

endmodule

// File: tb/tb_pacemaker_dual_param.sv
// Bench for pacemaker_dual_param: event-time reference model checked every cycle,
// directed pulse-timeline checks and randomized sensing/mode/reset traffic.
module tb_pacemaker_dual_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sa = 1'b0, sv = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       pa, pv, as_evt, vs_evt;
  logic [1:0] state;

  int tests = 0;
  int fails = 0;

  pacemaker_dual_param dut (
    .clk(clk), .rst(rst), .sa(sa), .sv(sv), .mode(mode),
    .pa(pa), .pv(pv), .as_evt(as_evt), .vs_evt(vs_evt), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: times of last V reference event and AV-delay start
  int         cyc = 0;
  int         m_ref = 0;
  int         m_av_start = 0;
  bit         m_in_av = 0;
  logic [1:0] m_mode = 2'b00;
  logic       e_pa = 0, e_pv = 0, e_as = 0, e_vs = 0;
  logic [1:0] e_state = 2'b00;
  bit         chk_en = 0;

  always @(posedge clk) begin
    int v, nxt;
    v   = cyc - m_ref;
    if (v > 65535) v = 65535;
    nxt = rst ? 0 : cyc + 1;
    e_pa = 0; e_pv = 0; e_as = 0; e_vs = 0;
    if (rst) begin
      m_mode = mode; m_in_av = 0; m_ref = nxt; e_state = 2'b00;
      chk_en = 1;
    end else if (mode != m_mode) begin
      m_mode = mode; m_in_av = 0; m_ref = nxt;
      e_state = (mode == 2'b11) ? 2'b10 : 2'b00;
    end else if (m_mode == 2'b11) begin
      m_in_av = 0; m_ref = nxt; e_state = 2'b10;
    end else if (m_mode == 2'b01) begin
      e_state = 2'b00;
      if (sv && v >= 20) begin e_vs = 1; m_ref = nxt; end
      else if (v == 99) begin e_pv = 1; m_ref = nxt; end
    end else if (m_mode == 2'b10) begin
      e_state = 2'b00;
      if (sa && v >= 25) begin e_as = 1; m_ref = nxt; end
      else if (v == 99) begin e_pa = 1; m_ref = nxt; end
    end else begin
      if (!m_in_av) begin
        if (sv && v >= 20) begin e_vs = 1; m_ref = nxt; end
        else if (sa && v >= 25) begin e_as = 1; m_in_av = 1; m_av_start = nxt; end
        else if (v == 69) begin e_pa = 1; m_in_av = 1; m_av_start = nxt; end
      end else begin
        if (sv && v >= 20) begin e_vs = 1; m_ref = nxt; m_in_av = 0; end
        else if ((cyc - m_av_start) >= 29 && v >= 59) begin
          e_pv = 1; m_ref = nxt; m_in_av = 0;
        end
      end
      e_state = m_in_av ? 2'b01 : 2'b00;
    end
    cyc = nxt;
  end

  // Per-cycle comparison plus pulse timeline logs
  string pa_s = "", pv_s = "", as_s = "", vs_s = "";

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({pa, pv, as_evt, vs_evt, state} !== {e_pa, e_pv, e_as, e_vs, e_state}) begin
        fails++;
        $display("FAIL model cyc=%0d got pa%b pv%b as%b vs%b st%b want pa%b pv%b as%b vs%b st%b",
                 cyc, pa, pv, as_evt, vs_evt, state, e_pa, e_pv, e_as, e_vs, e_state);
      end
      if (pa === 1'b1) pa_s = {pa_s, $sformatf("%0d ", cyc)};
      if (pv === 1'b1) pv_s = {pv_s, $sformatf("%0d ", cyc)};
      if (as_evt === 1'b1) as_s = {as_s, $sformatf("%0d ", cyc)};
      if (vs_evt === 1'b1) vs_s = {vs_s, $sformatf("%0d ", cyc)};
    end
  end

  task automatic check_str(input string name, input string got, input string exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got \"%s\" want \"%s\"", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    rst = 1; mode = m; sa = 0; sv = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    pa_s = ""; pv_s = ""; as_s = ""; vs_s = "";
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      fails++;
      $display("FAIL wait_cyc got %0d want %0d", cyc, n);
    end
  endtask

  task automatic pulse_sense(input int n, input bit a, input bit v);
    wait_cyc(n);
    sa = a; sv = v;
    @(negedge clk);
    sa = 0; sv = 0;
  endtask

  task automatic check_logs(input string tag, input string epa, input string epv,
                            input string eas, input string evs);
    check_str({tag, "_pa"}, pa_s, epa);
    check_str({tag, "_pv"}, pv_s, epv);
    check_str({tag, "_as"}, as_s, eas);
    check_str({tag, "_vs"}, vs_s, evs);
  endtask

  initial begin
    // 1: DDD free-running
    do_reset(2'b00);
    check_val("reset_state", int'(state), 0);
    check_val("reset_outs", int'({pa, pv, as_evt, vs_evt}), 0);
    wait_cyc(305);
    check_logs("t1", "70 170 270 ", "100 200 300 ", "", "");

    // 2: refractory sa ignored, then accepted sa
    do_reset(2'b00);
    pulse_sense(10, 1, 0);
    pulse_sense(30, 1, 0);
    wait_cyc(125);
    check_logs("t2", "", "61 ", "31 ", "");

    // 3: upper-rate extension
    do_reset(2'b00);
    pulse_sense(26, 1, 0);
    wait_cyc(57);
    check_val("t3_av_hold_state", int'(state), 1);
    wait_cyc(135);
    check_logs("t3", "130 ", "60 ", "27 ", "");

    // 4: refractory sv ignored, then PVC restart
    do_reset(2'b00);
    pulse_sense(10, 0, 1);
    pulse_sense(40, 0, 1);
    wait_cyc(150);
    check_logs("t4", "111 ", "141 ", "", "41 ");

    // 5: VVI, AAI, simultaneous senses in DDD
    do_reset(2'b01);
    wait_cyc(305);
    check_logs("t5_vvi", "", "100 200 300 ", "", "");
    do_reset(2'b10);
    wait_cyc(305);
    check_logs("t5_aai", "100 200 300 ", "", "", "");
    do_reset(2'b00);
    pulse_sense(40, 1, 1);
    wait_cyc(60);
    check_logs("t5_both", "", "", "", "41 ");

    // 6: OFF and back, then reset mid AV delay
    do_reset(2'b00);
    wait_cyc(50);
    mode = 2'b11;
    wait_cyc(100);
    check_val("t6_idle_state", int'(state), 2);
    wait_cyc(200);
    mode = 2'b00;
    wait_cyc(280);
    check_logs("t6_off", "271 ", "", "", "");
    do_reset(2'b00);
    wait_cyc(80);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_val("t6_rst_outs", int'({pa, pv, as_evt, vs_evt}), 0);
    wait_cyc(90);
    check_logs("t6_rst", "70 70 ", "", "", "");

    // Randomized traffic against the model
    do_reset(2'b00);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      sa  = ($urandom_range(0, 99) < 3);
      sv  = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 599) == 0) mode = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst = 0; sa = 0; sv = 0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
